// File: rtl/jala_pkg.sv
// Shared register-file writeback types and widths.
// Imported by the writeback FIFO and the writeback arbiter.
package jala_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    localparam logic [REG_ADDR_W-1:0] REG_X0 = 5'd0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       data;
    } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// DEPTH-deep synchronous FIFO holding pending LSU writebacks.
// Head is presented combinationally on dout; reset discards contents.
module wb_fifo
    import jala_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    push,
    input  logic    pop,
    input  wb_req_t din,
    output wb_req_t dout,
    output logic    empty,
    output logic    full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    wb_req_t         mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            do_push;
    logic            do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Owns the register-file write port: merges ALU and buffered LSU writebacks,
// tracks pending destinations for decode, and throttles the ALU on LSU starvation.
module regfile_wb_arbiter
    import jala_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  alu_wb_en,
    input  logic [REG_ADDR_W-1:0] alu_wb_addr,
    input  logic [XLEN-1:0]       alu_wb_data,
    input  logic                  lsu_wb_valid,
    output logic                  lsu_wb_ready,
    input  logic [REG_ADDR_W-1:0] lsu_wb_addr,
    input  logic [XLEN-1:0]       lsu_wb_data,
    input  logic                  issue_en,
    input  logic [REG_ADDR_W-1:0] issue_addr,
    input  logic [REG_ADDR_W-1:0] pend_addr1,
    input  logic [REG_ADDR_W-1:0] pend_addr2,
    output logic                  pend_hit1,
    output logic                  pend_hit2,
    output logic                  wb_stall,
    output logic                  rf_write_en,
    output logic [REG_ADDR_W-1:0] rf_write_addr,
    output logic [XLEN-1:0]       rf_write_data
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic                fifo_empty;
    logic                fifo_full;
    logic                fifo_push;
    logic                fifo_pop;
    logic                alu_sel;
    wb_req_t             fifo_head;
    wb_req_t             lsu_req;
    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] pending_next;
    logic [SW-1:0]       starve_cnt;
    logic [SW-1:0]       starve_next;

    // LSU handshake: a result transfers on a rising edge where lsu_wb_valid and
    // lsu_wb_ready are both high; ready depends only on registered FIFO state,
    // and x0 results still complete the handshake but are discarded.
    assign lsu_wb_ready = !fifo_full;
    assign lsu_req      = '{addr: lsu_wb_addr, data: lsu_wb_data};
    assign fifo_push    = lsu_wb_valid && lsu_wb_ready && (lsu_wb_addr != REG_X0);
    assign alu_sel      = alu_wb_en && (alu_wb_addr != REG_X0);
    assign fifo_pop     = !alu_sel && !fifo_empty;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (lsu_req),
        .dout  (fifo_head),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // Clear on pop is applied before set so a same-cycle issue keeps the bit.
    always_comb begin
        pending_next = pending;
        if (fifo_pop) begin
            pending_next[fifo_head.addr] = 1'b0;
        end
        if (issue_en && (issue_addr != REG_X0)) begin
            pending_next[issue_addr] = 1'b1;
        end
    end

    always_comb begin
        starve_next = starve_cnt;
        if (fifo_empty || fifo_pop) begin
            starve_next = '0;
        end else if (alu_sel && (starve_cnt != SW'(STARVE_LIMIT))) begin
            starve_next = starve_cnt + SW'(1);
        end
    end

    assign pend_hit1 = pending[pend_addr1];
    assign pend_hit2 = pending[pend_addr2];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending    <= '0;
            starve_cnt <= '0;
            wb_stall   <= 1'b0;
        end else begin
            pending    <= pending_next;
            starve_cnt <= starve_next;
            wb_stall   <= (starve_next == SW'(STARVE_LIMIT));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_write_en   <= 1'b0;
            rf_write_addr <= '0;
            rf_write_data <= '0;
        end else if (alu_sel) begin
            rf_write_en   <= 1'b1;
            rf_write_addr <= alu_wb_addr;
            rf_write_data <= alu_wb_data;
        end else if (fifo_pop) begin
            rf_write_en   <= 1'b1;
            rf_write_addr <= fifo_head.addr;
            rf_write_data <= fifo_head.data;
        end else begin
            rf_write_en   <= 1'b0;
            rf_write_addr <= '0;
            rf_write_data <= '0;
        end
    end

    // Decode and the ALU pipeline must never present these combinations.
    a_issue_not_pending : assert property (@(posedge clk) disable iff (reset)
        (issue_en && issue_addr != REG_X0) |-> !pending[issue_addr]);
    a_alu_not_pending : assert property (@(posedge clk) disable iff (reset)
        alu_wb_en |-> !pending[alu_wb_addr]);
    a_alu_honours_stall : assert property (@(posedge clk) disable iff (reset)
        wb_stall |-> !alu_wb_en);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, ALU path, LSU ordering,
// FIFO full with starvation stall, scoreboard set/clear and x0 handling.
module tb_regfile_wb_arbiter;
    import jala_pkg::*;

    logic                  clk;
    logic                  reset;
    logic                  alu_wb_en;
    logic [REG_ADDR_W-1:0] alu_wb_addr;
    logic [XLEN-1:0]       alu_wb_data;
    logic                  lsu_wb_valid;
    logic                  lsu_wb_ready;
    logic [REG_ADDR_W-1:0] lsu_wb_addr;
    logic [XLEN-1:0]       lsu_wb_data;
    logic                  issue_en;
    logic [REG_ADDR_W-1:0] issue_addr;
    logic [REG_ADDR_W-1:0] pend_addr1;
    logic [REG_ADDR_W-1:0] pend_addr2;
    logic                  pend_hit1;
    logic                  pend_hit2;
    logic                  wb_stall;
    logic                  rf_write_en;
    logic [REG_ADDR_W-1:0] rf_write_addr;
    logic [XLEN-1:0]       rf_write_data;

    int total;
    int bad;

    regfile_wb_arbiter #(.DEPTH(4), .STARVE_LIMIT(3)) dut (
        .clk           (clk),
        .reset         (reset),
        .alu_wb_en     (alu_wb_en),
        .alu_wb_addr   (alu_wb_addr),
        .alu_wb_data   (alu_wb_data),
        .lsu_wb_valid  (lsu_wb_valid),
        .lsu_wb_ready  (lsu_wb_ready),
        .lsu_wb_addr   (lsu_wb_addr),
        .lsu_wb_data   (lsu_wb_data),
        .issue_en      (issue_en),
        .issue_addr    (issue_addr),
        .pend_addr1    (pend_addr1),
        .pend_addr2    (pend_addr2),
        .pend_hit1     (pend_hit1),
        .pend_hit2     (pend_hit2),
        .wb_stall      (wb_stall),
        .rf_write_en   (rf_write_en),
        .rf_write_addr (rf_write_addr),
        .rf_write_data (rf_write_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        alu_wb_en    = 1'b0;
        alu_wb_addr  = '0;
        alu_wb_data  = '0;
        lsu_wb_valid = 1'b0;
        lsu_wb_addr  = '0;
        lsu_wb_data  = '0;
        issue_en     = 1'b0;
        issue_addr   = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_alu(input logic en, input logic [4:0] a, input logic [31:0] d);
        alu_wb_en = en; alu_wb_addr = a; alu_wb_data = d;
    endtask

    task automatic set_lsu(input logic v, input logic [4:0] a, input logic [31:0] d);
        lsu_wb_valid = v; lsu_wb_addr = a; lsu_wb_data = d;
    endtask

    task automatic test_reset();
        total++;
        if (rf_write_en !== 1'b0 || rf_write_addr !== 5'd0 || rf_write_data !== 32'd0) begin
            bad++; $display("FAIL reset_rf: en=%b addr=%0d data=%h want 0/0/0", rf_write_en, rf_write_addr, rf_write_data);
        end
        total++;
        if (lsu_wb_ready !== 1'b1 || wb_stall !== 1'b0) begin
            bad++; $display("FAIL reset_ready_stall: ready=%b stall=%b want 1/0", lsu_wb_ready, wb_stall);
        end
        // Queue two LSU results behind a busy ALU, then reset mid-stream.
        issue_en = 1'b1; issue_addr = 5'd3;
        set_alu(1'b1, 5'd20, 32'h20); set_lsu(1'b1, 5'd3, 32'h1);
        step();
        issue_en = 1'b0;
        set_alu(1'b1, 5'd21, 32'h21); set_lsu(1'b1, 5'd4, 32'h2);
        step();
        idle_inputs();
        pend_addr1 = 5'd3;
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (rf_write_en !== 1'b0 || wb_stall !== 1'b0) begin
            bad++; $display("FAIL midreset_outputs: en=%b stall=%b want 0/0", rf_write_en, wb_stall);
        end
        total++;
        if (lsu_wb_ready !== 1'b1 || pend_hit1 !== 1'b0) begin
            bad++; $display("FAIL midreset_ready_pend: ready=%b hit=%b want 1/0", lsu_wb_ready, pend_hit1);
        end
        @(posedge clk);
        #2;
        reset = 1'b0;
        step();
        total++;
        if (rf_write_en !== 1'b0) begin
            bad++; $display("FAIL midreset_fifo_empty: en=%b want 0", rf_write_en);
        end
    endtask

    task automatic test_alu_only();
        set_alu(1'b1, 5'd5, 32'h1234);
        step();
        total++;
        if (rf_write_en !== 1'b1 || rf_write_addr !== 5'd5 || rf_write_data !== 32'h1234) begin
            bad++; $display("FAIL alu_x5: en=%b addr=%0d data=%h want 1/5/00001234", rf_write_en, rf_write_addr, rf_write_data);
        end
        set_alu(1'b1, 5'd0, 32'hffff);
        step();
        total++;
        if (rf_write_en !== 1'b0) begin
            bad++; $display("FAIL alu_x0: en=%b want 0", rf_write_en);
        end
        idle_inputs();
        step();
    endtask

    task automatic test_lsu_order();
        issue_en = 1'b1; issue_addr = 5'd3;
        step();
        issue_addr = 5'd4;
        step();
        issue_en = 1'b0;
        pend_addr1 = 5'd3; pend_addr2 = 5'd4;
        #1;
        total++;
        if (pend_hit1 !== 1'b1 || pend_hit2 !== 1'b1) begin
            bad++; $display("FAIL lsu_pend_set: hit1=%b hit2=%b want 1/1", pend_hit1, pend_hit2);
        end
        set_lsu(1'b1, 5'd3, 32'hA);
        step();
        total++;
        if (rf_write_en !== 1'b0) begin
            bad++; $display("FAIL lsu_first_latency: en=%b want 0", rf_write_en);
        end
        set_lsu(1'b1, 5'd4, 32'hB);
        step();
        total++;
        if (rf_write_en !== 1'b1 || rf_write_addr !== 5'd3 || rf_write_data !== 32'hA) begin
            bad++; $display("FAIL lsu_write_x3: en=%b addr=%0d data=%h want 1/3/0000000a", rf_write_en, rf_write_addr, rf_write_data);
        end
        total++;
        if (pend_hit1 !== 1'b0 || pend_hit2 !== 1'b1) begin
            bad++; $display("FAIL lsu_pend_x3_clear: hit1=%b hit2=%b want 0/1", pend_hit1, pend_hit2);
        end
        set_lsu(1'b0, 5'd0, 32'h0);
        step();
        total++;
        if (rf_write_en !== 1'b1 || rf_write_addr !== 5'd4 || rf_write_data !== 32'hB || pend_hit2 !== 1'b0) begin
            bad++; $display("FAIL lsu_write_x4: en=%b addr=%0d data=%h hit2=%b want 1/4/0000000b/0", rf_write_en, rf_write_addr, rf_write_data, pend_hit2);
        end
        step();
        total++;
        if (rf_write_en !== 1'b0) begin
            bad++; $display("FAIL lsu_drained: en=%b want 0", rf_write_en);
        end
    endtask

    task automatic test_full();
        logic [4:0] exp_addr [5];
        exp_addr[0] = 5'd21; exp_addr[1] = 5'd22; exp_addr[2] = 5'd23;
        exp_addr[3] = 5'd24; exp_addr[4] = 5'd25;
        for (int i = 0; i < 4; i++) begin
            set_alu(1'b1, 5'(10 + i), 32'(16'hA0 + i));
            set_lsu(1'b1, exp_addr[i], 32'(12'h100 + i));
            step();
            total++;
            if (rf_write_en !== 1'b1 || rf_write_addr !== 5'(10 + i)) begin
                bad++; $display("FAIL full_alu_wins[%0d]: en=%b addr=%0d want 1/%0d", i, rf_write_en, rf_write_addr, 10 + i);
            end
            total++;
            if (wb_stall !== (i == 3)) begin
                bad++; $display("FAIL full_stall[%0d]: stall=%b want %b", i, wb_stall, (i == 3));
            end
        end
        set_alu(1'b0, 5'd0, 32'h0);
        set_lsu(1'b1, exp_addr[4], 32'h104);
        total++;
        if (lsu_wb_ready !== 1'b0) begin
            bad++; $display("FAIL full_ready: ready=%b want 0", lsu_wb_ready);
        end
        step();
        total++;
        if (rf_write_addr !== 5'd21 || rf_write_data !== 32'h100 || wb_stall !== 1'b0 || lsu_wb_ready !== 1'b1) begin
            bad++; $display("FAIL full_first_pop: addr=%0d data=%h stall=%b ready=%b want 21/00000100/0/1", rf_write_addr, rf_write_data, wb_stall, lsu_wb_ready);
        end
        step();
        set_lsu(1'b0, 5'd0, 32'h0);
        for (int i = 1; i < 5; i++) begin
            total++;
            if (rf_write_en !== 1'b1 || rf_write_addr !== exp_addr[i] || rf_write_data !== 32'(12'h100 + i)) begin
                bad++; $display("FAIL full_drain[%0d]: en=%b addr=%0d data=%h want 1/%0d/%h", i, rf_write_en, rf_write_addr, rf_write_data, exp_addr[i], 32'(12'h100 + i));
            end
            step();
        end
        total++;
        if (rf_write_en !== 1'b0) begin
            bad++; $display("FAIL full_drained: en=%b want 0", rf_write_en);
        end
    endtask

    task automatic test_scoreboard();
        issue_en = 1'b1; issue_addr = 5'd7;
        step();
        issue_en = 1'b0;
        pend_addr1 = 5'd7; pend_addr2 = 5'd8;
        #1;
        total++;
        if (pend_hit1 !== 1'b1 || pend_hit2 !== 1'b0) begin
            bad++; $display("FAIL sb_x7: hit1=%b hit2=%b want 1/0", pend_hit1, pend_hit2);
        end
        set_alu(1'b1, 5'd10, 32'h10); set_lsu(1'b1, 5'd9, 32'h99);
        step();
        idle_inputs();
        issue_en = 1'b1; issue_addr = 5'd9;
        step();
        issue_en = 1'b0;
        pend_addr2 = 5'd9;
        #1;
        total++;
        if (rf_write_en !== 1'b1 || rf_write_addr !== 5'd9 || rf_write_data !== 32'h99) begin
            bad++; $display("FAIL sb_pop_x9: en=%b addr=%0d data=%h want 1/9/00000099", rf_write_en, rf_write_addr, rf_write_data);
        end
        total++;
        if (pend_hit2 !== 1'b1) begin
            bad++; $display("FAIL sb_set_wins: hit2=%b want 1", pend_hit2);
        end
        step();
    endtask

    task automatic test_x0();
        set_alu(1'b1, 5'd12, 32'hC); set_lsu(1'b1, 5'd14, 32'hE);
        step();
        set_alu(1'b1, 5'd13, 32'hD); set_lsu(1'b1, 5'd0, 32'h55);
        total++;
        if (lsu_wb_ready !== 1'b1) begin
            bad++; $display("FAIL x0_ready: ready=%b want 1", lsu_wb_ready);
        end
        step();
        idle_inputs();
        step();
        total++;
        if (rf_write_en !== 1'b1 || rf_write_addr !== 5'd14 || rf_write_data !== 32'hE) begin
            bad++; $display("FAIL x0_pop_x14: en=%b addr=%0d data=%h want 1/14/0000000e", rf_write_en, rf_write_addr, rf_write_data);
        end
        step();
        total++;
        if (rf_write_en !== 1'b0) begin
            bad++; $display("FAIL x0_not_enqueued: en=%b want 0", rf_write_en);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        idle_inputs();
        pend_addr1 = '0;
        pend_addr2 = '0;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        step();
        test_reset();
        test_alu_only();
        test_lsu_order();
        test_full();
        test_scoreboard();
        test_x0();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
